// File: rtl/rank_sort_pkg.sv
// rank_sort_pkg: packed-vector element helpers and rank clamp shared by the sorter
// Helpers work on vectors zero-extended to MAX_N*MAX_W bits, so DATA_W and ID_W must not exceed MAX_W.
package rank_sort_pkg;
  localparam int MAX_N = 16;
  localparam int MAX_W = 32;
  typedef logic [MAX_N*MAX_W-1:0] vec_t;
  typedef logic [MAX_W-1:0] elem_t;
  function automatic elem_t get_elem(vec_t v, int k, int w);
    return elem_t'(v >> (k * w)) & elem_t'((64'd1 << w) - 64'd1);
  endfunction
  function automatic vec_t set_elem(vec_t v, int k, int w, elem_t e);
    vec_t m;
    m = vec_t'((64'd1 << w) - 64'd1) << (k * w);
    return (v & ~m) | ((vec_t'(e) << (k * w)) & m);
  endfunction
  function automatic int unsigned clamp_rank(int unsigned r, int unsigned n);
    return r >= n ? n - 1 : r;
  endfunction
endpackage

// File: rtl/rank_sort_pipe_cmp_swap_cell.sv
// cmp_swap_cell: combinational compare-exchange of one (data,id) pair; a = lower index, b = upper index
// Swaps only on strict a > b, so equal values keep their original order.
module cmp_swap_cell #(
  parameter int DATA_W = 8,
  parameter int ID_W = 4
) (
  input  logic [DATA_W-1:0] a_data_i,
  input  logic [ID_W-1:0]   a_id_i,
  input  logic [DATA_W-1:0] b_data_i,
  input  logic [ID_W-1:0]   b_id_i,
  output logic [DATA_W-1:0] lo_data_o,
  output logic [ID_W-1:0]   lo_id_o,
  output logic [DATA_W-1:0] hi_data_o,
  output logic [ID_W-1:0]   hi_id_o
);
  logic swap;
  assign swap = a_data_i > b_data_i;
  assign lo_data_o = swap ? b_data_i : a_data_i;
  assign lo_id_o = swap ? b_id_i : a_id_i;
  assign hi_data_o = swap ? a_data_i : b_data_i;
  assign hi_id_o = swap ? a_id_i : b_id_i;
endmodule

// File: rtl/rank_sort_pipe.sv
// rank_sort_pipe: N-stage odd-even transposition sorter with tags, ready/valid and rank select
// Ports: clk/reset (async high), in_valid/in_ready/in_data/in_id/in_rank upstream beat,
// out_valid/out_ready/out_data/out_id downstream sorted beat, out_sel_data/out_sel_id chosen rank.
module rank_sort_pipe
  import rank_sort_pkg::*;
#(
  parameter int N = 3,
  parameter int DATA_W = 8,
  parameter int ID_W = 4,
  parameter int RANK_W = $clog2(N)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N*DATA_W-1:0] in_data,
  input  logic [N*ID_W-1:0]   in_id,
  input  logic [RANK_W-1:0]   in_rank,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [N*DATA_W-1:0] out_data,
  output logic [N*ID_W-1:0]   out_id,
  output logic [DATA_W-1:0]   out_sel_data,
  output logic [ID_W-1:0]     out_sel_id
);
  logic [DATA_W-1:0] src_data [N][N];
  logic [DATA_W-1:0] data_d [N][N];
  logic [DATA_W-1:0] data_q [N][N];
  logic [ID_W-1:0] src_id [N][N];
  logic [ID_W-1:0] id_d [N][N];
  logic [ID_W-1:0] id_q [N][N];
  logic [RANK_W-1:0] rank_q [N];
  logic [N-1:0] valid_q;
  logic adv;
  vec_t pack_data, pack_id;
  // One global advance: the whole pipe freezes while the output is held.
  assign adv = ~valid_q[N-1] | out_ready;
  assign in_ready = adv;
  assign out_valid = valid_q[N-1];
  for (genvar s = 0; s < N; s++) begin : g_s
    for (genvar k = 0; k < N; k++) begin : g_k
      if (s == 0) begin : g_in
        assign src_data[s][k] = DATA_W'(get_elem(vec_t'(in_data), k, DATA_W));
        assign src_id[s][k] = ID_W'(get_elem(vec_t'(in_id), k, ID_W));
      end else begin : g_prev
        assign src_data[s][k] = data_q[s-1][k];
        assign src_id[s][k] = id_q[s-1][k];
      end
      // Stage parity picks which pairs compare; unpaired end elements pass straight through.
      if ((k % 2) == (s % 2) && k + 1 < N) begin : g_cell
        cmp_swap_cell #(.DATA_W(DATA_W), .ID_W(ID_W)) u_cell (
          .a_data_i (src_data[s][k]),
          .a_id_i   (src_id[s][k]),
          .b_data_i (src_data[s][k+1]),
          .b_id_i   (src_id[s][k+1]),
          .lo_data_o(data_d[s][k]),
          .lo_id_o  (id_d[s][k]),
          .hi_data_o(data_d[s][k+1]),
          .hi_id_o  (id_d[s][k+1])
        );
      end else if (k == 0 || ((k - 1) % 2) != (s % 2)) begin : g_pass
        assign data_d[s][k] = src_data[s][k];
        assign id_d[s][k] = src_id[s][k];
      end
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      for (int s = 0; s < N; s++) begin
        rank_q[s] <= '0;
        for (int k = 0; k < N; k++) begin
          data_q[s][k] <= '0;
          id_q[s][k] <= '0;
        end
      end
    end else if (adv) begin
      valid_q <= {valid_q[N-2:0], in_valid};
      rank_q[0] <= RANK_W'(clamp_rank(32'(in_rank), N));
      for (int s = 1; s < N; s++) rank_q[s] <= rank_q[s-1];
      data_q <= data_d;
      id_q <= id_d;
    end
  end
  always_comb begin
    pack_data = '0;
    pack_id = '0;
    for (int k = 0; k < N; k++) begin
      pack_data = set_elem(pack_data, k, DATA_W, elem_t'(data_q[N-1][k]));
      pack_id = set_elem(pack_id, k, ID_W, elem_t'(id_q[N-1][k]));
    end
    out_data = pack_data[N*DATA_W-1:0];
    out_id = pack_id[N*ID_W-1:0];
  end
  // Carried rank is already clamped to N-1, so the index is always in range.
  assign out_sel_data = data_q[N-1][rank_q[N-1]];
  assign out_sel_id = id_q[N-1][rank_q[N-1]];
endmodule

// File: tb/tb_rank_sort_pipe.sv
// tb_rank_sort_pipe: scoreboard bench for rank_sort_pipe at N=3 and N=9
module tb_rank_sort_pipe;
  logic clk = 0, reset = 1;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int checks = 0, errors = 0;

  logic in_valid3 = 0, in_ready3, out_valid3, out_ready3 = 1;
  logic [23:0] in_data3 = '0, out_data3;
  logic [11:0] in_id3 = '0, out_id3;
  logic [1:0] in_rank3 = '0;
  logic [7:0] out_sel_data3;
  logic [3:0] out_sel_id3;
  rank_sort_pipe #(.N(3), .DATA_W(8), .ID_W(4)) u3 (
    .clk(clk), .reset(reset), .in_valid(in_valid3), .in_ready(in_ready3),
    .in_data(in_data3), .in_id(in_id3), .in_rank(in_rank3),
    .out_valid(out_valid3), .out_ready(out_ready3), .out_data(out_data3),
    .out_id(out_id3), .out_sel_data(out_sel_data3), .out_sel_id(out_sel_id3));

  logic in_valid9 = 0, in_ready9, out_valid9, out_ready9 = 1;
  logic [71:0] in_data9 = '0, out_data9;
  logic [35:0] in_id9 = '0, out_id9;
  logic [3:0] in_rank9 = '0;
  logic [7:0] out_sel_data9;
  logic [3:0] out_sel_id9;
  rank_sort_pipe #(.N(9), .DATA_W(8), .ID_W(4)) u9 (
    .clk(clk), .reset(reset), .in_valid(in_valid9), .in_ready(in_ready9),
    .in_data(in_data9), .in_id(in_id9), .in_rank(in_rank9),
    .out_valid(out_valid9), .out_ready(out_ready9), .out_data(out_data9),
    .out_id(out_id9), .out_sel_data(out_sel_data9), .out_sel_id(out_sel_id9));

  typedef struct {
    logic [23:0] d;
    logic [11:0] id;
    logic [7:0] sd;
    logic [3:0] sid;
    int acc;
    bit lat;
  } exp_t;
  exp_t q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask

  // Monitor: pops on every accepted output; also checks hold stability and in_ready under stall.
  bit stall_prev = 0;
  logic [23:0] h_d;
  logic [11:0] h_id;
  logic [11:0] h_s;
  always @(negedge clk) begin
    exp_t e;
    if (reset) stall_prev = 0;
    else begin
      if (stall_prev) begin
        chk("hold_data", 64'(out_data3), 64'(h_d));
        chk("hold_id", 64'(out_id3), 64'(h_id));
        chk("hold_sel", 64'({out_sel_id3, out_sel_data3}), 64'(h_s));
      end
      stall_prev = out_valid3 && !out_ready3;
      if (stall_prev) begin
        chk("in_ready_stall", 64'(in_ready3), 64'(0));
        h_d = out_data3;
        h_id = out_id3;
        h_s = {out_sel_id3, out_sel_data3};
      end
      if (out_valid3 && out_ready3) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got data %0h with no beat outstanding", out_data3);
        end else begin
          e = q.pop_front();
          chk("out_data", 64'(out_data3), 64'(e.d));
          chk("out_id", 64'(out_id3), 64'(e.id));
          chk("sel_data", 64'(out_sel_data3), 64'(e.sd));
          chk("sel_id", 64'(out_sel_id3), 64'(e.sid));
          // Accepting edge + N-1 edges = N cycles after the beat was presented.
          if (e.lat) chk("latency", 64'(cyc - e.acc), 64'(2));
        end
      end
    end
  end

  task automatic send(input logic [7:0] a, b, c, input logic [3:0] i0, i1, i2, input logic [1:0] r,
                      input logic [7:0] s0, s1, s2, input logic [3:0] o0, o1, o2,
                      input logic [7:0] sd, input logic [3:0] sid, input bit lat, input bit push);
    exp_t e;
    bit acc = 0;
    in_valid3 = 1;
    in_data3 = {c, b, a};
    in_id3 = {i2, i1, i0};
    in_rank3 = r;
    for (int t = 0; t < 50 && !acc; t++) begin
      @(negedge clk);
      acc = in_ready3;
      @(posedge clk);
      #1;
    end
    in_valid3 = 0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready stayed 0 for 50 cycles");
    end else if (push) begin
      e.d = {s2, s1, s0};
      e.id = {o2, o1, o0};
      e.sd = sd;
      e.sid = sid;
      e.acc = cyc;
      e.lat = lat;
      q.push_back(e);
    end
  endtask

  task automatic drain();
    for (int t = 0; t < 200 && q.size() > 0; t++) @(posedge clk);
    #1;
    chk("drain", 64'(q.size()), 64'(0));
  endtask

  // Backpressure stream: inputs, ranks, sorted data, sorted ids, selected data/id.
  int tin[10][3] = '{'{3,1,2}, '{9,9,1}, '{4,5,6}, '{6,5,4}, '{0,255,128},
                     '{200,100,150}, '{7,7,3}, '{1,1,1}, '{50,40,60}, '{2,3,1}};
  int trk[10] = '{0, 2, 1, 0, 2, 1, 0, 1, 3, 2};
  int tso[10][3] = '{'{1,2,3}, '{1,9,9}, '{4,5,6}, '{4,5,6}, '{0,128,255},
                     '{100,150,200}, '{3,7,7}, '{1,1,1}, '{40,50,60}, '{1,2,3}};
  int tid[10][3] = '{'{1,2,0}, '{2,0,1}, '{0,1,2}, '{2,1,0}, '{0,2,1},
                     '{1,2,0}, '{2,0,1}, '{0,1,2}, '{1,0,2}, '{2,0,1}};
  int tsd[10] = '{1, 9, 5, 4, 255, 150, 3, 1, 60, 3};
  int tsi[10] = '{1, 1, 1, 2, 1, 2, 2, 1, 2, 1};

  initial begin
    logic [71:0] ed9;
    logic [35:0] ei9;
    int acc9;
    bit seen;
    #7;
    chk("rst_in_ready", 64'(in_ready3), 64'(1));
    chk("rst_out_valid", 64'(out_valid3), 64'(0));
    chk("rst_out", 64'({out_data3, out_id3}), 64'(0));
    chk("rst_sel", 64'({out_sel_data3, out_sel_id3}), 64'(0));
    #5 reset = 0;
    @(posedge clk);
    #1;
    // Case 1
    send(30,10,20, 0,1,2, 1, 10,20,30, 1,2,0, 20, 2, 1, 1);
    drain();
    // Case 2: ties keep index order
    send(5,5,5, 0,1,2, 0, 5,5,5, 0,1,2, 5, 0, 1, 1);
    send(7,3,7, 4,5,6, 2, 3,7,7, 5,4,6, 7, 6, 1, 1);
    drain();
    // Case 4: back-to-back stream with a 4-cycle out_ready drop
    fork
      for (int i = 0; i < 10; i++)
        send(tin[i][0], tin[i][1], tin[i][2], 0, 1, 2, trk[i][1:0],
             tso[i][0], tso[i][1], tso[i][2], tid[i][0], tid[i][1], tid[i][2],
             tsd[i], tsi[i], 0, 1);
      begin
        repeat (4) @(posedge clk);
        #1 out_ready3 = 0;
        repeat (4) @(posedge clk);
        #1 out_ready3 = 1;
      end
    join
    drain();
    // Case 5: rank 3 saturates to max
    send(1,2,3, 0,1,2, 3, 1,2,3, 0,1,2, 3, 2, 1, 1);
    drain();
    // Case 3: N=9 reversed input
    for (int k = 0; k < 9; k++) begin
      in_data9[k*8 +: 8] = 8'(9 - k);
      in_id9[k*4 +: 4] = 4'(k);
      ed9[k*8 +: 8] = 8'(k + 1);
      ei9[k*4 +: 4] = 4'(8 - k);
    end
    in_rank9 = 4;
    in_valid9 = 1;
    @(posedge clk);
    #1;
    acc9 = cyc;
    in_valid9 = 0;
    seen = 0;
    for (int t = 0; t < 40 && !seen; t++) begin
      @(negedge clk);
      seen = out_valid9;
    end
    chk("n9_valid", 64'(out_valid9), 64'(1));
    chk("n9_latency", 64'(cyc - acc9), 64'(8));
    chk("n9_data", 64'(out_data9), 64'(ed9));
    chk("n9_id", 64'(out_id9), 64'(ei9));
    chk("n9_sel", 64'({out_sel_id9, out_sel_data9}), 64'({4'd4, 8'd5}));
    @(posedge clk);
    #1;
    // Case 6: async reset with two beats in flight
    send(40,20,30, 0,1,2, 0, 20,30,40, 1,2,0, 20, 1, 0, 0);
    send(8,6,7, 3,4,5, 1, 6,7,8, 4,5,3, 7, 5, 0, 0);
    #3 reset = 1;
    #1;
    chk("midrst_valid", 64'(out_valid3), 64'(0));
    chk("midrst_out", 64'({out_data3, out_id3}), 64'(0));
    chk("midrst_sel", 64'({out_sel_data3, out_sel_id3}), 64'(0));
    chk("midrst_in_ready", 64'(in_ready3), 64'(1));
    #8 reset = 0;
    repeat (8) @(posedge clk);
    #1;
    send(30,10,20, 0,1,2, 1, 10,20,30, 1,2,0, 20, 2, 1, 1);
    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
